gpr_mp: RTL and testbench

//   Parametrised multi-port general-purpose register file for RISC-V cores, including superscalar variants.

---
 rtl/gpr_mp.sv | 130 +++++++++++++
 tb/tb_gpr_mp.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_mp.sv
// Multi-port GPR file: zero-latency reads with optional write bypass, x0 hardwired to zero,
// a pending-write scoreboard, and a post-reset sequencer that zeroes x1..x(GPRN-1).
module gpr_mp #(
  parameter int REG_WIDTH      = 32,
  parameter int GPRN           = 32,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(GPRN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_RD*AW-1:0]        rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*AW-1:0]        wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
  input  logic                        sb_set,
  input  logic [AW-1:0]               sb_addr,
  output logic                        init_done,
  output logic                        wr_conflict
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [GPRN-1:0]      busy_q, busy_d;
  logic                 init_done_q, init_done_d;
  logic                 wr_conflict_q, wr_conflict_d;
  logic [REG_WIDTH-1:0] regs_q [GPRN];
  logic [REG_WIDTH-1:0] regs_d [GPRN];

  logic [AW-1:0]        ra;
  logic [REG_WIDTH-1:0] rdat;
  logic                 rbsy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (CLEAR_ON_RESET == 0 || cnt_q == AW'(GPRN - 1)) state_d = S_RUN;
    end
    init_done_d = (state_d == S_RUN);
  end

  // Ports are visited in ascending order so the highest-index writer wins a shared address;
  // the scoreboard set is applied after the write clears so it overrides them.
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    if (state_q == S_INIT) begin
      if (CLEAR_ON_RESET != 0) regs_d[cnt_q] = '0;
    end else if (en) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w]) begin
          if (wr_addr[w*AW +: AW] != '0)
            regs_d[wr_addr[w*AW +: AW]] = wr_data[w*REG_WIDTH +: REG_WIDTH];
          busy_d[wr_addr[w*AW +: AW]] = 1'b0;
        end
      end
      for (int a = 0; a < NUM_WR; a++) begin
        for (int b = a + 1; b < NUM_WR; b++) begin
          if (wr_en[a] && wr_en[b] && wr_addr[a*AW +: AW] == wr_addr[b*AW +: AW] &&
              wr_addr[a*AW +: AW] != '0)
            wr_conflict_d = 1'b1;
        end
      end
      if (sb_set) busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      cnt_q         <= AW'(1);
      busy_q        <= '0;
      init_done_q   <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      init_done_q   <= init_done_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Storage carries no reset; the INIT sequence defines its contents.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbsy    = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra   = rd_addr[p*AW +: AW];
      rdat = regs_q[ra];
      rbsy = busy_q[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (en && wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
            rdat = wr_data[w*REG_WIDTH +: REG_WIDTH];
            rbsy = 1'b0;
          end
        end
      end
      if (ra == '0 || !en || state_q != S_RUN) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      rd_data[p*REG_WIDTH +: REG_WIDTH] = rdat;
      rd_busy[p]                        = rbsy;
    end
  end

  assign init_done   = init_done_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench: a 2-write-port bypassing instance and a 1-write-port non-bypassing instance share stimulus.
module tb_gpr_mp;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        init_done;
  logic        wr_conflict;
  logic [63:0] rd_data_nb;
  logic [1:0]  rd_busy_nb;
  logic        init_done_nb;
  logic        wr_conflict_nb;

  int chk_cnt;
  int pass_cnt;

  gpr_mp #(.REG_WIDTH(32), .GPRN(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .init_done(init_done), .wr_conflict(wr_conflict)
  );

  gpr_mp #(.REG_WIDTH(32), .GPRN(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]), .sb_set(sb_set), .sb_addr(sb_addr),
    .init_done(init_done_nb), .wr_conflict(wr_conflict_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; rd_addr = {5'd31, 5'd4}; wr_en = 2'b00;
    wr_addr = '0; wr_data = '0; sb_set = 1'b0; sb_addr = '0;
    #3;
    chk_cnt++; if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b exp 0", init_done); else pass_cnt++;
    chk_cnt++; if (wr_conflict !== 1'b0) $display("FAIL rst_wr_conflict: got %b exp 0", wr_conflict); else pass_cnt++;
    chk_cnt++; if (rd_data !== 64'h0) $display("FAIL rst_rd_data: got %h exp 0", rd_data); else pass_cnt++;
    chk_cnt++; if (rd_busy !== 2'b00) $display("FAIL rst_rd_busy: got %b exp 00", rd_busy); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Writes and scoreboard sets held during INIT must be ignored.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h0000FFFF}; sb_set = 1'b1; sb_addr = 5'd4;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 15) begin
        chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL init_rd_zero: got %h exp 0", rd_data[31:0]); else pass_cnt++;
      end
      if (k == 30) begin
        chk_cnt++; if (init_done !== 1'b0) $display("FAIL init_done_k30: got %b exp 0", init_done); else pass_cnt++;
      end
      if (k == 31) begin
        chk_cnt++; if (init_done !== 1'b1) $display("FAIL init_done_k31: got %b exp 1", init_done); else pass_cnt++;
        chk_cnt++; if (init_done_nb !== 1'b1) $display("FAIL init_done_nb_k31: got %b exp 1", init_done_nb); else pass_cnt++;
      end
    end
    wr_en = 2'b00; sb_set = 1'b0;
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL init_x4_ignored: got %h exp 0", rd_data[31:0]); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL init_sb_ignored: got %b exp 0", rd_busy[0]); else pass_cnt++;
    chk_cnt++; if (rd_data[63:32] !== 32'h0) $display("FAIL init_x31_clear: got %h exp 0", rd_data[63:32]); else pass_cnt++;
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd0, 5'd6};
    tick();
    wr_en = 2'b00; rd_addr = {5'd0, 5'd5};
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'hDEADBEEF) $display("FAIL wr_rd_x5: got %h exp deadbeef", rd_data[31:0]); else pass_cnt++;
    chk_cnt++; if (rd_data_nb[31:0] !== 32'hDEADBEEF) $display("FAIL wr_rd_x5_nb: got %h exp deadbeef", rd_data_nb[31:0]); else pass_cnt++;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h00001234}; rd_addr = {5'd0, 5'd0};
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL x0_no_bypass: got %h exp 0", rd_data[31:0]); else pass_cnt++;
    tick();
    wr_en = 2'b00;
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL x0_write_discard: got %h exp 0", rd_data[31:0]); else pass_cnt++;
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h11111111}; rd_addr = {5'd0, 5'd0};
    tick();
    wr_en = 2'b00; sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0; rd_addr = {5'd7, 5'd0};
    #1;
    chk_cnt++; if (rd_busy[1] !== 1'b1) $display("FAIL x7_busy: got %b exp 1", rd_busy[1]); else pass_cnt++;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5}; rd_addr = {5'd0, 5'd7};
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'hA5A5A5A5) $display("FAIL byp_data: got %h exp a5a5a5a5", rd_data[31:0]); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL byp_busy: got %b exp 0", rd_busy[0]); else pass_cnt++;
    chk_cnt++; if (rd_data_nb[31:0] !== 32'h11111111) $display("FAIL nobyp_data: got %h exp 11111111", rd_data_nb[31:0]); else pass_cnt++;
    chk_cnt++; if (rd_busy_nb[0] !== 1'b1) $display("FAIL nobyp_busy: got %b exp 1", rd_busy_nb[0]); else pass_cnt++;
    tick();
    wr_en = 2'b00;
    #1;
    chk_cnt++; if (rd_data_nb[31:0] !== 32'hA5A5A5A5) $display("FAIL nobyp_after: got %h exp a5a5a5a5", rd_data_nb[31:0]); else pass_cnt++;
    chk_cnt++; if (rd_busy_nb[0] !== 1'b0) $display("FAIL nobyp_busy_clr: got %b exp 0", rd_busy_nb[0]); else pass_cnt++;
  endtask

  task automatic test_dual_write();
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h2, 32'h1}; rd_addr = {5'd0, 5'd9};
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h2) $display("FAIL dual_byp_prio: got %h exp 2", rd_data[31:0]); else pass_cnt++;
    chk_cnt++; if (wr_conflict !== 1'b0) $display("FAIL conflict_pre: got %b exp 0", wr_conflict); else pass_cnt++;
    tick();
    wr_en = 2'b00;
    #1;
    chk_cnt++; if (wr_conflict !== 1'b1) $display("FAIL conflict_set: got %b exp 1", wr_conflict); else pass_cnt++;
    chk_cnt++; if (rd_data[31:0] !== 32'h2) $display("FAIL dual_x9: got %h exp 2", rd_data[31:0]); else pass_cnt++;
    tick();
    chk_cnt++; if (wr_conflict !== 1'b0) $display("FAIL conflict_one_cycle: got %b exp 0", wr_conflict); else pass_cnt++;
    wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h5, 32'h6};
    tick();
    chk_cnt++; if (wr_conflict !== 1'b0) $display("FAIL conflict_x0: got %b exp 0", wr_conflict); else pass_cnt++;
    wr_addr = {5'd11, 5'd10}; wr_data = {32'hBBBB0011, 32'hAAAA0010};
    tick();
    wr_en = 2'b00; rd_addr = {5'd11, 5'd10};
    #1;
    chk_cnt++; if (wr_conflict !== 1'b0) $display("FAIL conflict_distinct: got %b exp 0", wr_conflict); else pass_cnt++;
    chk_cnt++; if (rd_data !== 64'hBBBB0011_AAAA0010) $display("FAIL dual_distinct: got %h exp bbbb0011aaaa0010", rd_data); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_addr = 5'd3; rd_addr = {5'd3, 5'd0};
    tick();
    sb_set = 1'b0;
    #1;
    chk_cnt++; if (rd_busy[1] !== 1'b1) $display("FAIL sb_set_x3: got %b exp 1", rd_busy[1]); else pass_cnt++;
    sb_set = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
    tick();
    sb_set = 1'b0; wr_en = 2'b00;
    #1;
    chk_cnt++; if (rd_busy[1] !== 1'b1) $display("FAIL sb_set_wins: got %b exp 1", rd_busy[1]); else pass_cnt++;
    chk_cnt++; if (rd_data[63:32] !== 32'h33) $display("FAIL sb_x3_data: got %h exp 33", rd_data[63:32]); else pass_cnt++;
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h44, 32'h0};
    tick();
    wr_en = 2'b00;
    #1;
    chk_cnt++; if (rd_busy[1] !== 1'b0) $display("FAIL sb_clear_p1: got %b exp 0", rd_busy[1]); else pass_cnt++;
    chk_cnt++; if (rd_data[63:32] !== 32'h44) $display("FAIL sb_x3_p1_data: got %h exp 44", rd_data[63:32]); else pass_cnt++;
    en = 1'b0; rd_addr = {5'd12, 5'd3}; sb_set = 1'b1; sb_addr = 5'd12; wr_en = 2'b01;
    wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h99};
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL en0_rd: got %h exp 0", rd_data[31:0]); else pass_cnt++;
    tick();
    en = 1'b1; sb_set = 1'b0; wr_en = 2'b00;
    #1;
    chk_cnt++; if (rd_busy[1] !== 1'b0) $display("FAIL en0_sb_ignored: got %b exp 0", rd_busy[1]); else pass_cnt++;
    chk_cnt++; if (rd_data[63:32] !== 32'h0) $display("FAIL en0_wr_ignored: got %h exp 0", rd_data[63:32]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_init();
    sb_set = 1'b1; sb_addr = 5'd5; rd_addr = {5'd0, 5'd5};
    tick();
    sb_set = 1'b0;
    #1;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL pre_rst_busy: got %b exp 1", rd_busy[0]); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0)
      $display("FAIL rst_outputs: got data %h busy %b exp 0/0", rd_data[31:0], rd_busy[0]); else pass_cnt++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) tick();
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (init_done !== 1'b0) $display("FAIL mid_init_done: got %b exp 0", init_done); else pass_cnt++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 30) begin
        chk_cnt++; if (init_done !== 1'b0) $display("FAIL restart_k30: got %b exp 0", init_done); else pass_cnt++;
      end
    end
    chk_cnt++; if (init_done !== 1'b1) $display("FAIL restart_k31: got %b exp 1", init_done); else pass_cnt++;
    #1;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL restart_sb_clear: got %b exp 0", rd_busy[0]); else pass_cnt++;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL restart_x5_clear: got %h exp 0", rd_data[31:0]); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
